// File: rtl/load_store_buffer_pkg.sv
// Shared encodings for the load/store buffer: RV32I funct3 widths, memory size codes, FSM states.
package load_store_buffer_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DRAIN    = 2'd2
  } lsb_state_t;

endpackage

// File: rtl/load_store_buffer_if.sv
// Issue, broadcast, memory and ROB-result signals of the load/store buffer; slave = the buffer itself.
interface load_store_buffer_if
  import load_store_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) ();

  // Handshakes: addValid is taken on any edge where full was low (full keeps one slot of slack);
  // memValid stays high with stable request fields until the edge that samples the memDone pulse;
  // lsbUpdate and rsUpdate are single-cycle broadcasts with no back-pressure.
  logic                 clear;
  logic                 addValid;
  logic [ROB_WIDTH-1:0] addRobIndex;
  logic                 addIsStore;
  logic [2:0]           addFunct3;
  logic [31:0]          addOffset;
  logic                 addBaseReady;
  logic [31:0]          addBaseVal;
  logic [ROB_WIDTH-1:0] addBaseDep;
  logic                 addDataReady;
  logic [31:0]          addDataVal;
  logic [ROB_WIDTH-1:0] addDataDep;
  logic                 rsUpdate;
  logic [ROB_WIDTH-1:0] rsRobIndex;
  logic [31:0]          rsUpdateVal;
  logic [ROB_WIDTH-1:0] robBeginId;
  logic                 beginValid;
  logic                 full;
  logic                 memValid;
  logic                 memWrite;
  logic [31:0]          memAddr;
  logic [1:0]           memSize;
  logic [31:0]          memWData;
  logic                 memDone;
  logic [31:0]          memRData;
  logic                 lsbUpdate;
  logic [ROB_WIDTH-1:0] lsbRobIndex;
  logic [31:0]          lsbUpdateVal;
  lsb_state_t           state;

  modport master (
    output clear, addValid, addRobIndex, addIsStore, addFunct3, addOffset,
           addBaseReady, addBaseVal, addBaseDep, addDataReady, addDataVal, addDataDep,
           rsUpdate, rsRobIndex, rsUpdateVal, robBeginId, beginValid, memDone, memRData,
    input  full, memValid, memWrite, memAddr, memSize, memWData,
           lsbUpdate, lsbRobIndex, lsbUpdateVal, state
  );

  modport slave (
    input  clear, addValid, addRobIndex, addIsStore, addFunct3, addOffset,
           addBaseReady, addBaseVal, addBaseDep, addDataReady, addDataVal, addDataDep,
           rsUpdate, rsRobIndex, rsUpdateVal, robBeginId, beginValid, memDone, memRData,
    output full, memValid, memWrite, memAddr, memSize, memWData,
           lsbUpdate, lsbRobIndex, lsbUpdateVal, state
  );

endinterface

// File: rtl/load_store_buffer_mem_data_extend.sv
// Maps funct3 to the memory access size and sign/zero-extends a right-aligned load word.
module mem_data_extend
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o,
  output logic [1:0]  size_o
);

  always_comb begin
    ext_o  = raw_i;
    size_o = SIZE_W;
    case (funct3_i)
      F3_B:  begin ext_o = {{24{raw_i[7]}}, raw_i[7:0]};   size_o = SIZE_B; end
      F3_H:  begin ext_o = {{16{raw_i[15]}}, raw_i[15:0]}; size_o = SIZE_H; end
      F3_BU: begin ext_o = {24'b0, raw_i[7:0]};            size_o = SIZE_B; end
      F3_HU: begin ext_o = {16'b0, raw_i[15:0]};           size_o = SIZE_H; end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: captures ops at issue, snoops operand broadcasts, runs one memory
// access at a time from the head and reports results to the ROB.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = 4,
  parameter int LSB_WIDTH = 3
) (
  input logic               clockIn,
  input logic               resetIn,
  load_store_buffer_if.slave bus
);

  localparam int LSB_SIZE = 2 ** LSB_WIDTH;
  localparam logic [LSB_WIDTH-1:0] PTR_ONE = LSB_WIDTH'(1);
  localparam logic [LSB_WIDTH:0]   CNT_ONE = (LSB_WIDTH+1)'(1);
  localparam logic [LSB_WIDTH:0]   CNT_MAX = (LSB_WIDTH+1)'(LSB_SIZE);
  localparam logic [LSB_WIDTH:0]   FULL_AT = (LSB_WIDTH+1)'(LSB_SIZE - 1);

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] rob;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [31:0]          offset;
    logic                 base_rdy;
    logic [31:0]          base_val;
    logic [ROB_WIDTH-1:0] base_dep;
    logic                 data_rdy;
    logic [31:0]          data_val;
    logic [ROB_WIDTH-1:0] data_dep;
  } entry_t;

  entry_t               ent_q [LSB_SIZE];
  entry_t               ent_d [LSB_SIZE];
  entry_t               new_e, head_e;
  logic [LSB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [LSB_WIDTH:0]   count_q, count_d;
  lsb_state_t           state_q, state_d;
  logic                 mem_valid_q, mem_valid_d, mem_write_q, mem_write_d;
  logic [31:0]          mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 upd_q, upd_d;
  logic [ROB_WIDTH-1:0] upd_rob_q, upd_rob_d;
  logic [31:0]          upd_val_q, upd_val_d;
  logic                 push, pop, issue_ok;
  logic [31:0]          ext_val;
  logic [1:0]           ext_size;

  // An operand not yet ready picks up a matching RS or own-result broadcast in the same cycle.
  function automatic logic [32:0] resolve(
    input logic rdy, input logic [31:0] val, input logic [ROB_WIDTH-1:0] dep,
    input logic rs_v, input logic [ROB_WIDTH-1:0] rs_tag, input logic [31:0] rs_val,
    input logic ls_v, input logic [ROB_WIDTH-1:0] ls_tag, input logic [31:0] ls_val);
    if (rdy)                         return {1'b1, val};
    else if (rs_v && rs_tag == dep)  return {1'b1, rs_val};
    else if (ls_v && ls_tag == dep)  return {1'b1, ls_val};
    else                             return {1'b0, val};
  endfunction

  assign head_e = ent_q[head_q];

  mem_data_extend u_ext (
    .funct3_i (head_e.funct3),
    .raw_i    (bus.memRData),
    .ext_o    (ext_val),
    .size_o   (ext_size)
  );

  assign issue_ok = head_e.valid && head_e.base_rdy &&
                    (!head_e.is_store ||
                     (head_e.data_rdy && bus.beginValid && bus.robBeginId == head_e.rob));

  always_comb begin
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
    upd_d       = 1'b0;
    upd_rob_d   = '0;
    upd_val_d   = '0;
    new_e       = '0;
    push        = bus.addValid && (count_q != CNT_MAX);
    pop         = 1'b0;

    for (int i = 0; i < LSB_SIZE; i++) begin
      if (ent_q[i].valid) begin
        {ent_d[i].base_rdy, ent_d[i].base_val} = resolve(ent_q[i].base_rdy, ent_q[i].base_val,
          ent_q[i].base_dep, bus.rsUpdate, bus.rsRobIndex, bus.rsUpdateVal, upd_q, upd_rob_q, upd_val_q);
        {ent_d[i].data_rdy, ent_d[i].data_val} = resolve(ent_q[i].data_rdy, ent_q[i].data_val,
          ent_q[i].data_dep, bus.rsUpdate, bus.rsRobIndex, bus.rsUpdateVal, upd_q, upd_rob_q, upd_val_q);
      end
    end

    new_e.valid    = 1'b1;
    new_e.rob      = bus.addRobIndex;
    new_e.is_store = bus.addIsStore;
    new_e.funct3   = bus.addFunct3;
    new_e.offset   = bus.addOffset;
    new_e.base_dep = bus.addBaseDep;
    new_e.data_dep = bus.addDataDep;
    {new_e.base_rdy, new_e.base_val} = resolve(bus.addBaseReady, bus.addBaseVal, bus.addBaseDep,
      bus.rsUpdate, bus.rsRobIndex, bus.rsUpdateVal, upd_q, upd_rob_q, upd_val_q);
    {new_e.data_rdy, new_e.data_val} = resolve(bus.addDataReady, bus.addDataVal, bus.addDataDep,
      bus.rsUpdate, bus.rsRobIndex, bus.rsUpdateVal, upd_q, upd_rob_q, upd_val_q);

    case (state_q)
      ST_IDLE: if (issue_ok) begin
        mem_valid_d = 1'b1;
        mem_write_d = head_e.is_store;
        mem_addr_d  = head_e.base_val + head_e.offset;
        mem_size_d  = ext_size;
        mem_wdata_d = head_e.is_store ? head_e.data_val : 32'h0;
        state_d     = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: if (bus.memDone) begin
        pop         = 1'b1;
        mem_valid_d = 1'b0;
        mem_write_d = 1'b0;
        upd_d       = 1'b1;
        upd_rob_d   = head_e.rob;
        upd_val_d   = head_e.is_store ? 32'h0 : ext_val;
        state_d     = ST_IDLE;
      end
      ST_DRAIN: if (bus.memDone) begin
        mem_valid_d = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.clear) begin
      // A request already on the bus must still finish; loads and stores alike then go silent.
      for (int i = 0; i < LSB_SIZE; i++) ent_d[i].valid = 1'b0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      upd_d     = 1'b0;
      upd_rob_d = '0;
      upd_val_d = '0;
      if (state_q == ST_IDLE) begin
        mem_valid_d = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_IDLE;
      end else if (state_q == ST_WAIT_MEM && !bus.memDone) begin
        state_d = ST_DRAIN;
      end
    end else begin
      if (pop) begin
        ent_d[head_q].valid = 1'b0;
        head_d = head_q + PTR_ONE;
      end
      if (push) begin
        ent_d[tail_q] = new_e;
        tail_d = tail_q + PTR_ONE;
      end
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      for (int i = 0; i < LSB_SIZE; i++) ent_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      mem_wdata_q <= '0;
      upd_q       <= 1'b0;
      upd_rob_q   <= '0;
      upd_val_q   <= '0;
    end else begin
      ent_q       <= ent_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
      upd_q       <= upd_d;
      upd_rob_q   <= upd_rob_d;
      upd_val_q   <= upd_val_d;
    end
  end

  assign bus.full         = (count_q >= FULL_AT);
  assign bus.memValid     = mem_valid_q;
  assign bus.memWrite     = mem_write_q;
  assign bus.memAddr      = mem_addr_q;
  assign bus.memSize      = mem_size_q;
  assign bus.memWData     = mem_wdata_q;
  assign bus.lsbUpdate    = upd_q;
  assign bus.lsbRobIndex  = upd_rob_q;
  assign bus.lsbUpdateVal = upd_val_q;
  assign bus.state        = state_q;

  add_when_full_a: assert property (@(posedge clockIn) disable iff (!resetIn)
    !(bus.addValid && !bus.clear && count_q == CNT_MAX));

endmodule
